// File: rtl/copper.sv
// Copper coprocessor: fetches MOVE/WAIT/SKIP instruction pairs over a DMA port
// and drives MOVE results onto the custom-register write bus.
module copper (
  input  logic        clk,
  input  logic        reset,
  input  logic        ecs,
  input  logic        dma_enable,
  input  logic        blit_busy,
  input  logic [15:0] data_in,
  input  logic [8:1]  reg_address_in,
  input  logic [8:0]  hpos,
  input  logic [10:0] vpos,
  input  logic        eof,
  output logic        dma_req,
  input  logic        dma_ack,
  output logic [20:1] address_out,
  output logic [8:1]  reg_address_out,
  output logic [15:0] data_out
);

  typedef enum logic [2:0] {
    STOP    = 3'd0,
    FETCH1  = 3'd1,
    FETCH2  = 3'd2,
    EXEC    = 3'd3,
    WAITING = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        cdang_q, cdang_d;
  logic [20:1] cop1lc_q, cop1lc_d;
  logic [20:1] cop2lc_q, cop2lc_d;
  logic [20:1] pc_q, pc_d;
  logic [15:0] ir1_q, ir1_d;
  logic [15:0] ir2_q, ir2_d;
  logic        wait_hit_q, wait_hit_d;
  logic        dma_req_q, dma_req_d;
  logic [20:1] address_out_q, address_out_d;
  logic [8:1]  reg_address_out_q, reg_address_out_d;
  logic [15:0] data_out_q, data_out_d;

  logic        copjmp1, copjmp2, restart, ack;
  logic [7:0]  v_mask;
  logic [6:0]  h_mask;
  logic [14:0] beam_pos, beam_ref;
  logic        beam_match;
  logic        unused_beam_bits;

  assign unused_beam_bits = ^{hpos[1:0], vpos[10:8]};

  function automatic logic move_legal(input logic [8:1] addr, input logic cd, input logic ecs_en);
    if (addr >= 8'h40)
      return 1'b1;
    else if (addr >= 8'h20)
      return cd;
    else
      return cd & ecs_en;
  endfunction

  assign copjmp1 = (reg_address_in == 8'h44);
  assign copjmp2 = (reg_address_in == 8'h45);
  assign restart = eof | copjmp1 | copjmp2;
  assign ack     = dma_req_q & dma_ack;

  // Beam compare shared by WAIT and SKIP; vertical bit 7 can never be masked.
  assign v_mask     = {1'b1, ir2_q[14:8]};
  assign h_mask     = ir2_q[7:1];
  assign beam_pos   = {vpos[7:0] & v_mask, hpos[8:2] & h_mask};
  assign beam_ref   = {ir1_q[15:8] & v_mask, ir1_q[7:1] & h_mask};
  assign beam_match = (beam_pos >= beam_ref) && (ir2_q[15] || !blit_busy);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= STOP;
      cdang_q           <= 1'b0;
      cop1lc_q          <= '0;
      cop2lc_q          <= '0;
      pc_q              <= '0;
      ir1_q             <= '0;
      ir2_q             <= '0;
      wait_hit_q        <= 1'b0;
      dma_req_q         <= 1'b0;
      address_out_q     <= '0;
      reg_address_out_q <= 8'hFF;
      data_out_q        <= '0;
    end else begin
      state_q           <= state_d;
      cdang_q           <= cdang_d;
      cop1lc_q          <= cop1lc_d;
      cop2lc_q          <= cop2lc_d;
      pc_q              <= pc_d;
      ir1_q             <= ir1_d;
      ir2_q             <= ir2_d;
      wait_hit_q        <= wait_hit_d;
      dma_req_q         <= dma_req_d;
      address_out_q     <= address_out_d;
      reg_address_out_q <= reg_address_out_d;
      data_out_q        <= data_out_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cdang_d  = cdang_q;
    cop1lc_d = cop1lc_q;
    cop2lc_d = cop2lc_q;
    pc_d     = pc_q;
    ir1_d    = ir1_q;
    ir2_d    = ir2_q;

    case (reg_address_in)
      8'h17:   cdang_d = data_in[1];
      8'h40:   cop1lc_d[20:16] = data_in[4:0];
      8'h41:   cop1lc_d[15:1] = data_in[15:1];
      8'h42:   cop2lc_d[20:16] = data_in[4:0];
      8'h43:   cop2lc_d[15:1] = data_in[15:1];
      default: ;
    endcase

    case (state_q)
      STOP: ;
      FETCH1: begin
        if (ack) begin
          ir1_d   = data_in;
          pc_d    = pc_q + 20'd1;
          state_d = FETCH2;
        end
      end
      FETCH2: begin
        if (ack) begin
          ir2_d   = data_in;
          pc_d    = pc_q + 20'd1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (!ir1_q[0])
          state_d = move_legal(ir1_q[8:1], cdang_q, ecs) ? FETCH1 : STOP;
        else if (!ir2_q[0])
          state_d = WAITING;
        else begin
          if (beam_match)
            pc_d = pc_q + 20'd2;
          state_d = FETCH1;
        end
      end
      WAITING: begin
        if (wait_hit_q)
          state_d = FETCH1;
      end
      default: state_d = STOP;
    endcase

    // A restart overrides whatever the sequencer decided, including a same-cycle ack.
    if (restart) begin
      state_d = FETCH1;
      pc_d    = copjmp2 ? cop2lc_q : cop1lc_q;
    end

    wait_hit_d = (state_q == WAITING) && (state_d == WAITING) && beam_match;
  end

  always_comb begin
    dma_req_d         = dma_enable && (state_d == FETCH1 || state_d == FETCH2);
    address_out_d     = pc_d;
    reg_address_out_d = 8'hFF;
    data_out_d        = '0;
    // The MOVE write is registered so it shows up during the EXEC cycle.
    if (state_d == EXEC && !ir1_q[0] && move_legal(ir1_q[8:1], cdang_q, ecs)) begin
      reg_address_out_d = ir1_q[8:1];
      data_out_d        = ir2_d;
    end
  end

  assign dma_req         = dma_req_q;
  assign address_out     = address_out_q;
  assign reg_address_out = reg_address_out_q;
  assign data_out        = data_out_q;

endmodule

// File: doc/copper.md
# copper

Copper coprocessor for the Agnus side of the chipset. It consumes the beam position (`hpos`, `vpos`) and the end-of-frame strobe from the beam counter. It fetches two-word instructions from chip RAM through a request/acknowledge DMA port and executes MOVE, WAIT and SKIP. MOVE results are driven onto the custom-register write bus, where they are merged with CPU writes upstream of every register decoder.

## Interface
Parameters: none.

Ports:
- `clk` — input, 1 — bus clock.
- `reset` — input, 1 — synchronous, active-high reset.
- `ecs` — input, 1 — ECS enable; changes the MOVE protection rules.
- `dma_enable` — input, 1 — DMACON copper enable (COPEN AND DMAEN).
- `blit_busy` — input, 1 — blitter busy; used by the WAIT/SKIP blitter-finish-disable (BFD) bit.
- `data_in` — input, 16 — chip bus data; carries CPU register writes and DMA read data.
- `reg_address_in` — input, 8 [8:1] — CPU register write address.
- `hpos` — input, 9 — horizontal beam counter; `hpos[8:1]` counts CCKs.
- `vpos` — input, 11 — vertical beam counter.
- `eof` — input, 1 — one-`clk` end-of-frame strobe.
- `dma_req` — output, 1 — fetch request.
- `dma_ack` — input, 1 — one-`clk` grant; `data_in` is valid in the same cycle.
- `address_out` — output, 20 [20:1] — chip RAM word address of the fetch.
- `reg_address_out` — output, 8 [8:1] — MOVE destination; 8'hFF (0x1FE, NOOP) when idle.
- `data_out` — output, 16 — MOVE data; 0 when idle.

## Operation
- Registers are written via `reg_address_in` and `data_in` in the same cycle:
  - COPCON 0x02E: `cdang` = bit 1.
  - COP1LCH 0x080 / COP1LCL 0x082: `cop1lc[20:16]` / `cop1lc[15:1]`.
  - COP2LCH 0x084 / COP2LCL 0x086: `cop2lc[20:16]` / `cop2lc[15:1]`.
  - COPJMP1 0x088 / COPJMP2 0x08A: strobe only, data ignored.
- Restart sources:
  - `eof` or COPJMP1 loads `pc <= cop1lc`; COPJMP2 loads `pc <= cop2lc`.
  - A restart aborts any state, including a pending fetch or WAIT, and sets state FETCH1.
  - If `eof` and COPJMP2 occur in the same cycle, COPJMP2 wins.
- States:
  - STOP — no requests. Left only by a restart.
  - FETCH1 — request at `pc`. On ack: `ir1 <= data_in`, `pc <= pc+1`, go to FETCH2.
  - FETCH2 — request at `pc`. On ack: `ir2 <= data_in`, `pc <= pc+1`, go to EXEC.
  - EXEC — one cycle.
    - `ir1[0]==0` → MOVE: if the destination is legal, drive `reg_address_out = ir1[8:1]` and `data_out = ir2` for this cycle only, then go to FETCH1; if it is illegal, drive nothing and go to STOP.
    - `ir1[0]==1`, `ir2[0]==0` → WAIT: go to WAITING.
    - `ir1[0]==1`, `ir2[0]==1` → SKIP: if the compare is true, `pc <= pc+2`; go to FETCH1.
  - WAITING — when the compare is true, go to FETCH1 in the next cycle.
- MOVE legality:
  - Address ≥ 0x080: always legal.
  - Address 0x040–0x07E: legal only if `cdang`.
  - Address < 0x040: legal only if `cdang` and `ecs`.
- Compare (WAIT and SKIP):
  - `V = vpos[7:0]`, `H = hpos[8:2]`.
  - `VE = {1'b1, ir2[14:8]}`, `HE = ir2[7:1]`.
  - True when `{V & VE, H & HE} >= {ir1[15:8] & VE, ir1[7:1] & HE}`, an unsigned 15-bit compare.
  - It additionally requires `!blit_busy` when `ir2[15]==0`.
- `dma_enable` low:
  - `dma_req` is forced to 0 and the FETCH states hold.
  - WAITING and STOP evaluate normally; restarts still load `pc`.

## Timing
- Reset values:
  - State STOP.
  - `dma_req` 0, `address_out` 0.
  - `reg_address_out` 8'hFF, `data_out` 0.
  - `cop1lc`, `cop2lc`, `pc`, `cdang`, `ir1`, `ir2` all 0.
- All outputs are registered.
  - `dma_req` is registered high while the next state is FETCH1/FETCH2 and `dma_enable` is 1.
  - `address_out` equals `pc` whenever `dma_req` is 1.
- `dma_ack` is ignored while `dma_req` is 0.
  - `dma_req` stays high across FETCH1→FETCH2 with no gap.
  - It drops the cycle after the FETCH2 ack.
- MOVE write appears on the cycle after the FETCH2 ack, for exactly one cycle.
- WAIT: the first FETCH1 request is asserted two cycles after the compare first evaluates true.
- A restart in the same cycle as `dma_ack`: the ack is discarded and `pc` takes the new location.
- `pc` wraps modulo 2^20 words.

## Test plan
- COP1LC=0x01000 → `eof` → `dma_req` rises next cycle, `address_out`=0x00800 (word address).
- List MOVE 0x180,0x0F00 → one-cycle `reg_address_out`=0xC0, `data_out`=0x0F00 → next fetch at 0x00802.
- MOVE to 0x040 with `cdang`=0 → no write, STOP, `dma_req` 0 until COPJMP1 → resumes at `cop1lc`.
- WAIT 0x2C07,0xFFFE at `vpos`=0x2B, sweep `hpos` → fetch resumes only after `vpos`=0x2C and `hpos[8:2]`≥3. With BFD=0 and `blit_busy`=1 the wait persists until `blit_busy` falls.
- SKIP with a true compare → next instruction skipped (`pc`+2); with a false compare → executed.
- COPJMP2 during WAITING, and `eof` coincident with `dma_ack` → restart wins; `address_out` = new location.
